// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between NREQ requesters, the round-robin arbiter and
// one async-FIFO write port. The arbiter connects through the master modport.
interface fifo_wr_arb_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               push;
    logic [DW-1:0]      wdata;
    logic               full;
    logic [OW-1:0]      owner;
    logic               busy;

    modport master (
        input  req_valid, req_data, req_last, full,
        output req_ready, push, wdata, owner, busy
    );

    modport slave (
        output req_valid, req_data, req_last, full,
        input  req_ready, push, wdata, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that lets NREQ requesters share one async-FIFO write
// port, granting bursts of up to MAX_BURST words with an IDLE bubble between grants.
module fifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 2
) (
    input  logic           wclk,
    input  logic           reset,
    fifo_wr_arb_if.master  bus
);
    localparam int          OW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  BURST4 = 4'(MAX_BURST);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner_q, last_owner_q;
    logic [3:0]      count_q;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   idx;
    logic            pick_vld;
    logic            push_i;

    // Round-robin search starting just above the previous owner, wrapping to 0.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = OW'((int'(last_owner_q) + k) % NREQ);
            if (!pick_vld && bus.req_valid[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state        <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(NREQ - 1);
            count_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                owner_q <= pick;
                count_q <= '0;
            end
            if (push_i) begin
                count_q <= count_q + 4'd1;
            end
            if (state == XFER && state_nxt == IDLE) begin
                last_owner_q <= owner_q;
            end
        end
    end

    // While full is high the grant is frozen; abandonment is only judged when full=0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_vld) state_nxt = XFER;
            end
            XFER: begin
                if (!bus.full) begin
                    if (!bus.req_valid[owner_q]) begin
                        state_nxt = IDLE;
                    end else if (bus.req_last[owner_q] || (count_q + 4'd1 == BURST4)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are masked while reset is sampled so an interrupted burst never pushes.
    always_comb begin
        push_i        = 1'b0;
        bus.req_ready = '0;
        if (state == XFER && !reset) begin
            push_i = bus.req_valid[owner_q] && !bus.full;
        end
        if (push_i) begin
            bus.req_ready[owner_q] = 1'b1;
        end
        bus.push  = push_i;
        bus.wdata = bus.req_data[int'(owner_q) * DW +: DW];
        bus.owner = reset ? '0 : owner_q;
        bus.busy  = (state == XFER) && !reset;
    end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters sharing one async-FIFO write port; legal 2..8.
REQ-002 Parameter DW, default 8: data width per requester.
REQ-003 Parameter MAX_BURST, default 2: max words per grant; legal 1..15.
REQ-004 wclk  input  1  write-domain clock; all logic on its rising edge; single clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NREQ  bit i: requester i has a word.
REQ-007 req_data  input  NREQ*DW  word of requester i at bits [i*DW +: DW].
REQ-008 req_last  input  NREQ  bit i: the current word is requester i's final word.
REQ-009 req_ready  output  NREQ  bit i: word of requester i accepted this cycle.
REQ-010 push  output  1  write strobe to FIFO write port.
REQ-011 wdata  output  DW  data to FIFO write port.
REQ-012 full  input  1  registered full flag from FIFO write side.
REQ-013 owner  output  clog2(NREQ)  current grant holder.
REQ-014 busy  output  1  high in state XFER.

Function
REQ-015 FSM states SHALL be IDLE and XFER, held in one register.
REQ-016 IDLE: if any req_valid, the arbiter SHALL select round-robin, searching upward from last_owner+1 mod NREQ, register owner, clear burst count, and enter XFER next cycle; otherwise it remains in IDLE.
REQ-017 Arbitration latency: first accepted word SHALL be no earlier than the cycle after the request is first seen in IDLE.
REQ-018 XFER: push SHALL equal req_valid[owner] AND NOT full; req_ready[owner] SHALL equal push; all other req_ready bits SHALL be 0.
REQ-019 wdata SHALL equal the req_data slice of owner combinationally; wdata is don't-care when push=0.
REQ-020 In IDLE, push and all req_ready SHALL be 0.
REQ-021 A 4-bit burst counter SHALL increment on each push in XFER.
REQ-022 XFER SHALL exit to IDLE on the cycle after any of: push with req_last[owner]; push making count equal MAX_BURST; req_valid[owner]=0 with full=0 (owner abandons grant).
REQ-023 When full=1, XFER SHALL hold owner, count and state with push=0; abandonment SHALL NOT be evaluated while full=1.
REQ-024 On XFER exit, last_owner SHALL be loaded with owner; a one-cycle IDLE bubble SHALL separate consecutive grants.
REQ-025 A requester SHALL NOT be granted twice in succession while another requester is asserting valid in IDLE.
REQ-026 Simultaneous valid and full on the first XFER cycle: no push; the word SHALL be retried on the first cycle full=0.
REQ-027 The NREQ-1 to 0 wrap in the round-robin search SHALL be seamless.

Reset
REQ-028 With reset=1 at a wclk edge, the block SHALL take state IDLE, owner=0, last_owner=NREQ-1, count=0.
REQ-029 Outputs during and after reset until the first grant: push=0, req_ready=0, busy=0, owner=0.
REQ-030 Reset mid-burst SHALL abort the grant with no push in the cycle reset is sampled; the next grant starts from requester 0 priority.

Verification
REQ-031 After reset, req_valid=4'b0110, full=0, req_last=0 -> owner=1, two pushes (MAX_BURST=2), IDLE bubble, then owner=2.
REQ-032 req_valid=4'b1001 held continuously -> grant order 0,3,0,3; no requester granted twice consecutively.
REQ-033 Owner 2 in XFER, full=1 for 3 cycles -> push=0 and req_ready=0 for 3 cycles, owner stays 2, push resumes on the cycle full falls.
REQ-034 Owner 1, req_last[1]=1 on the first word -> exactly one push; busy falls next cycle; count is not carried over.
REQ-035 Reset asserted one cycle after the first push of a burst from owner 3 -> no push in the reset cycle; next grant with req_valid=4'b1111 is requester 0.
REQ-036 Owner 0 drops req_valid with full=0 before any push -> return to IDLE with zero pushes; the next grant goes to requester 1 when valid.
